// File: rtl/irq_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : irq_pkg                                                          |
// | Purpose : Shared types and constants for the interrupt controller slice.   |
// |           irq_state_t - controller FSM states                              |
// |           RESET_VEC / EXC_VEC / IRQ_VEC - PC vector addresses              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIGNAL  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0004;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0008;

endpackage
`default_nettype wire

// File: rtl/irq_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : irq_controller_if                                              |
// | Purpose   : Bundles the request, PC, config, ack and status signals of     |
// |             the interrupt controller.                                      |
// |   master : drives src_req, ia, pcin, cfg_we, cfg_mask, cfg_clr, ack        |
// |   slave  : drives irq, cause, epc, pending, busy                           |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface irq_controller_if #(
  parameter int NUM_SRC = 4
);
  localparam int CW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] src_req;
  logic [31:0]        ia;
  logic [31:0]        pcin;
  logic               cfg_we;
  logic [NUM_SRC-1:0] cfg_mask;
  logic [NUM_SRC-1:0] cfg_clr;
  logic               ack;

  logic               irq;
  logic [CW-1:0]      cause;
  logic [31:0]        epc;
  logic [NUM_SRC-1:0] pending;
  logic               busy;

  modport master (
    output src_req, ia, pcin, cfg_we, cfg_mask, cfg_clr, ack,
    input  irq, cause, epc, pending, busy
  );

  modport slave (
    input  src_req, ia, pcin, cfg_we, cfg_mask, cfg_clr, ack,
    output irq, cause, epc, pending, busy
  );
endinterface
`default_nettype wire

// File: rtl/irq_controller_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_arbiter                                                       |
// | Purpose : Combinational round-robin pick. Returns the first set request    |
// |           strictly after index 'last', wrapping around.                    |
// |   req       in  N          request vector                                  |
// |   last      in  clog2(N)   previously granted index                        |
// |   gnt_valid out 1          at least one request present                    |
// |   gnt_id    out clog2(N)   granted index                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);
  localparam int W = $clog2(N);

  logic [N-1:0] rot;
  int           start;
  int           pos;
  int           idx;
  logic         found;

  always_comb begin
    // Rotate so that index last+1 lands on bit 0; works for non power-of-2 N.
    start = (int'(last) + 1) % N;
    rot   = N'({req, req} >> start);
    pos   = 0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        pos   = k;
        found = 1'b1;
      end
    end
    idx       = (start + pos) % N;
    gnt_valid = |req;
    gnt_id    = W'(idx);
  end
endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : irq_controller                                                   |
// | Purpose : Edge-detects NUM_SRC interrupt lines into pending bits, picks    |
// |           one eligible source round-robin, raises irq toward the PC        |
// |           register and captures epc/cause when the vector is taken.        |
// |   clk      in  1   system clock                                            |
// |   reset_n  in  1   asynchronous active-low reset                           |
// |   bus      slave modport of irq_controller_if (requests, PC, config, ack,  |
// |            irq/cause/epc/pending/busy)                                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_controller_if.slave    bus
);
  localparam int CW = $clog2(NUM_SRC);

  irq_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [CW-1:0]      cause_q, cause_d;
  logic [CW-1:0]      last_q, last_d;
  logic [31:0]        epc_q, epc_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] take_clr;
  logic               gnt_valid;
  logic [CW-1:0]      gnt_id;
  logic               user_mode;
  logic               unused_ia;

  assign user_mode = ~bus.ia[31];
  assign unused_ia = ^bus.ia[30:0];
  assign rise      = bus.src_req & ~src_q;
  assign eligible  = pending_q & mask_q;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req       (eligible),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    last_d   = last_q;
    epc_d    = epc_q;
    irq_d    = 1'b0;
    take_clr = '0;
    src_d    = bus.src_req;
    mask_d   = bus.cfg_we ? bus.cfg_mask : mask_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid && user_mode) begin
          state_d = SIGNAL;
          cause_d = gnt_id;
          last_d  = gnt_id;
          irq_d   = 1'b1;
        end
      end
      SIGNAL: begin
        // The grant is committed here; mask/clear writes cannot revoke it.
        if (user_mode) begin
          epc_d    = bus.pcin;
          take_clr = NUM_SRC'(1) << cause_q;
          state_d  = SERVICE;
        end else begin
          irq_d = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // New edges are OR-ed last so a same-cycle set beats any clear.
    pending_d = (pending_q & ~bus.cfg_clr & ~take_clr) | rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= '0;
      last_q    <= CW'(NUM_SRC - 1);
      epc_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      last_q    <= last_d;
      epc_q     <= epc_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.irq     = irq_q;
  assign bus.cause   = cause_q;
  assign bus.epc     = epc_q;
  assign bus.pending = pending_q;
  assign bus.busy    = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_irq_controller                                                |
// | Purpose : Directed self-checking bench for irq_controller (NUM_SRC=4).     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_irq_controller;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  irq_controller_if #(.NUM_SRC(4)) bus ();

  irq_controller #(.NUM_SRC(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_src(input logic [3:0] v);
    bus.src_req = v;
    step();
    bus.src_req = 4'b0;
  endtask

  task automatic set_mask(input logic [3:0] m);
    bus.cfg_we   = 1'b1;
    bus.cfg_mask = m;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.src_req  = 4'b0;
    bus.ia       = 32'h0000_0100;
    bus.pcin     = 32'h0000_0104;
    bus.cfg_we   = 1'b0;
    bus.cfg_mask = 4'b0;
    bus.cfg_clr  = 4'b0;
    bus.ack      = 1'b0;
    step();
    step();
    check_eq("rst_irq",  32'(bus.irq),  32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;

    // ---- single source ----
    set_mask(4'b0001);
    pulse_src(4'b0001);
    check_eq("t2_pend_set", 32'(bus.pending), 32'h1);
    check_eq("t2_irq_T",    32'(bus.irq),     32'd0);
    step();
    check_eq("t2_irq_T1",   32'(bus.irq),     32'd1);
    check_eq("t2_busy_sig", 32'(bus.busy),    32'd1);
    step();
    check_eq("t2_epc",      bus.epc,          32'h0000_0104);
    check_eq("t2_cause",    32'(bus.cause),   32'd0);
    check_eq("t2_pend_clr", 32'(bus.pending), 32'h0);
    check_eq("t2_irq_off",  32'(bus.irq),     32'd0);
    check_eq("t2_busy_svc", 32'(bus.busy),    32'd1);

    // ---- reset while in SERVICE ----
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t1_irq",   32'(bus.irq),     32'd0);
    check_eq("t1_busy",  32'(bus.busy),    32'd0);
    check_eq("t1_epc",   bus.epc,          32'd0);
    check_eq("t1_cause", 32'(bus.cause),   32'd0);
    check_eq("t1_pend",  32'(bus.pending), 32'd0);
    check_eq("t1_mask",  32'(dut.mask_q),  32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("t1_idle",  32'(bus.busy),    32'd0);

    // ---- round robin ----
    set_mask(4'hF);
    pulse_src(4'b1010);
    check_eq("t3_pend", 32'(bus.pending), 32'hA);
    step();
    check_eq("t3_cause_a", 32'(bus.cause), 32'd1);
    check_eq("t3_irq_a",   32'(bus.irq),   32'd1);
    step();
    check_eq("t3_pend_a", 32'(bus.pending), 32'h8);
    do_ack();
    check_eq("t3_ack_busy", 32'(bus.busy), 32'd0);
    step();
    check_eq("t3_cause_b", 32'(bus.cause), 32'd3);
    check_eq("t3_irq_b",   32'(bus.irq),   32'd1);
    step();
    do_ack();
    pulse_src(4'b1010);
    step();
    check_eq("t3_cause_c", 32'(bus.cause), 32'd1);
    step();
    do_ack();
    step();
    step();
    check_eq("t3_cause_d", 32'(bus.cause), 32'd3);
    step();
    do_ack();

    // ---- kernel mode hold ----
    bus.ia = 32'h8000_0010;
    pulse_src(4'b0001);
    step();
    check_eq("t4_kern_nogrant", 32'(bus.irq), 32'd0);
    bus.ia = 32'h0000_0100;
    step();
    check_eq("t4_irq",   32'(bus.irq),   32'd1);
    check_eq("t4_cause", 32'(bus.cause), 32'd0);
    bus.ia   = 32'h8000_0010;
    bus.pcin = 32'h8000_0014;
    step();
    step();
    check_eq("t4_hold_irq", 32'(bus.irq), 32'd1);
    check_eq("t4_hold_epc", bus.epc,      32'h0000_0104);
    bus.ia   = 32'h0000_0200;
    bus.pcin = 32'h0000_0204;
    step();
    check_eq("t4_epc",     bus.epc,          32'h0000_0204);
    check_eq("t4_irq_off", 32'(bus.irq),     32'd0);
    check_eq("t4_pend",    32'(bus.pending), 32'h0);
    do_ack();

    // ---- masked source, clear, set-beats-clear ----
    set_mask(4'b1011);
    pulse_src(4'b0100);
    step();
    check_eq("t5_pend_masked", 32'(bus.pending), 32'h4);
    check_eq("t5_irq_masked",  32'(bus.irq),     32'd0);
    set_mask(4'hF);
    check_eq("t5_irq_mask_edge", 32'(bus.irq),   32'd0);
    step();
    check_eq("t5_irq_unmask", 32'(bus.irq),   32'd1);
    check_eq("t5_cause",      32'(bus.cause), 32'd2);
    bus.cfg_clr = 4'b0100;
    step();
    bus.cfg_clr = 4'b0000;
    check_eq("t5_committed", 32'(bus.busy), 32'd1);
    check_eq("t5_epc",       bus.epc,       32'h0000_0204);
    bus.src_req = 4'b0100;
    bus.cfg_clr = 4'b0100;
    step();
    bus.src_req = 4'b0000;
    bus.cfg_clr = 4'b0000;
    check_eq("t5_set_wins", 32'(bus.pending), 32'h4);
    bus.cfg_clr = 4'b0100;
    step();
    bus.cfg_clr = 4'b0000;
    check_eq("t5_clr", 32'(bus.pending), 32'h0);
    do_ack();

    // ---- ack outside SERVICE, edge during SERVICE ----
    do_ack();
    check_eq("t6_ack_idle", 32'(bus.busy), 32'd0);
    pulse_src(4'b0010);
    step();
    check_eq("t6_sig_cause", 32'(bus.cause), 32'd1);
    bus.ia  = 32'h8000_0010;
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check_eq("t6_ack_sig_irq", 32'(bus.irq), 32'd1);
    bus.ia = 32'h0000_0300;
    bus.pcin = 32'h0000_0304;
    step();
    check_eq("t6_epc", bus.epc, 32'h0000_0304);
    pulse_src(4'b1000);
    step();
    check_eq("t6_svc_pend",  32'(bus.pending), 32'h8);
    check_eq("t6_svc_noirq", 32'(bus.irq),     32'd0);
    check_eq("t6_svc_busy",  32'(bus.busy),    32'd1);
    do_ack();
    step();
    check_eq("t6_after_irq",   32'(bus.irq),   32'd1);
    check_eq("t6_after_cause", 32'(bus.cause), 32'd3);
    step();
    do_ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
